adc_scan_seq: RTL

// Scan sequencer directly upstream of the SPI ADC read FSM. Walks an N_ROWS x N_COLS

---
 rtl/adc_scan_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_seq.sv
// Row/column scan sequencer for the bolometer ADC path: select, settle, trigger a
// conversion, capture the tagged sample and hand it downstream over valid/ready.
`timescale 1ns/1ps
module adc_scan_seq #(
    parameter int N_ROWS      = 4,
    parameter int N_COLS      = 4,
    parameter int ROW_W       = 2,
    parameter int COL_W       = 2,
    parameter int DATA_W      = 16,
    parameter int SETTLE_CYC  = 100,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic              stop_i,
    input  logic              eor_i,
    input  logic              hab_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              data_ready_i,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic              strr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ROW_W-1:0]  data_row_o,
    output logic [COL_W-1:0]  data_col_o,
    output logic              data_valid_o,
    output logic              frame_done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int CNT_W = 16;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT_CONV,
        S_OUTPUT,
        S_NEXT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic               r_strr;
    logic [DATA_W-1:0]  r_data;
    logic [ROW_W-1:0]   r_data_row;
    logic [COL_W-1:0]   r_data_col;
    logic               r_valid;
    logic               r_frame_done;
    logic               r_err;

    logic w_abort;
    logic w_settle_done;
    logic w_timeout;
    logic w_last_pixel;
    logic w_take_sample;
    logic w_timeout_hit;
    logic w_fire;

    // stop_i outranks every other event once a scan is running
    assign w_abort       = stop_i && (r_state != S_IDLE);
    assign w_settle_done = (r_cnt == CNT_W'(SETTLE_CYC - 1));
    assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_last_pixel  = (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_take_sample = (r_state == S_WAIT_CONV) && !w_abort && hab_i;
    assign w_timeout_hit = (r_state == S_WAIT_CONV) && !w_abort && !hab_i && w_timeout;
    assign w_fire        = (r_state == S_START) && !w_abort && eor_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (start_i) w_state_next = S_SETTLE;
            S_SETTLE:    if (w_settle_done) w_state_next = S_START;
            S_START:     if (eor_i) w_state_next = S_WAIT_CONV;
            S_WAIT_CONV: if (hab_i || w_timeout) w_state_next = S_OUTPUT;
            S_OUTPUT:    if (data_ready_i) w_state_next = S_NEXT;
            S_NEXT: begin
                if (w_last_pixel && !continuous_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_SETTLE;
                end
            end
            default:     w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
        end
    end

    // One counter serves both the settle delay and the conversion timeout
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == S_SETTLE || r_state == S_WAIT_CONV) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_abort || (r_state == S_IDLE && start_i)) begin
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == S_NEXT) begin
            if (r_col != COL_LAST) begin
                r_col <= r_col + COL_W'(1);
            end else begin
                r_col <= '0;
                if (r_row != ROW_LAST) begin
                    r_row <= r_row + ROW_W'(1);
                end else if (continuous_i) begin
                    r_row <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_strr       <= 1'b0;
            r_frame_done <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_data_row   <= '0;
            r_data_col   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_strr       <= w_fire;
            r_frame_done <= (r_state == S_NEXT) && !w_abort && w_last_pixel;

            if (w_abort) begin
                r_valid <= 1'b0;
            end else if (w_take_sample || w_timeout_hit) begin
                r_valid <= 1'b1;
            end else if (r_state == S_OUTPUT && data_ready_i) begin
                r_valid <= 1'b0;
            end

            if (w_take_sample || w_timeout_hit) begin
                r_data     <= w_take_sample ? adc_data_i : {DATA_W{1'b1}};
                r_data_row <= r_row;
                r_data_col <= r_col;
            end

            if (r_state == S_IDLE && start_i) begin
                r_err <= 1'b0;
            end else if (w_timeout_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign row_o        = r_row;
    assign col_o        = r_col;
    assign strr_o       = r_strr;
    assign data_o       = r_data;
    assign data_row_o   = r_data_row;
    assign data_col_o   = r_data_col;
    assign data_valid_o = r_valid;
    assign frame_done_o = r_frame_done;
    assign busy_o       = (r_state != S_IDLE);
    assign err_o        = r_err;

endmodule
